// File: rtl/shell_pkg.sv
// Shared types for the shell pool: tank heading and per-slot state.
package shell_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    IDLE = 1'b0,
    FLY  = 1'b1
  } slot_state_t;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shell_slot.sv
// One shell slot: IDLE/FLY FSM, step divider, position and arena-edge handling.
// SHELL_EDGE_KILL_EN: leaving the arena frees the slot and pulses edge_kill.
module shell_slot
  import shell_pkg::*;
#(
  parameter int POS_W    = 6,
  parameter int STEP_DIV = 400000,
  parameter int X_MAX    = 39,
  parameter int Y_MAX    = 29
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             claim,
  input  logic             vanish,
  input  logic [1:0]       dir_in,
  input  logic [POS_W-1:0] tank_x,
  input  logic [POS_W-1:0] tank_y,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic             active,
  output logic             edge_kill
);

  localparam int               CNT_W    = idx_w(STEP_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);
  localparam logic [POS_W-1:0] XM       = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] YM       = POS_W'(Y_MAX);

  slot_state_t      r_state, w_state_nxt;
  dir_t             r_dir;
  logic [POS_W-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_step, w_at_edge, w_edge_kill;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_step = (r_state == FLY) && (r_cnt == CNT_LAST);

  always_comb begin
    w_at_edge = 1'b0;
    case (r_dir)
      UP:    w_at_edge = (r_y >= YM);
      DOWN:  w_at_edge = (r_y == '0);
      LEFT:  w_at_edge = (r_x == '0);
      RIGHT: w_at_edge = (r_x >= XM);
      default: w_at_edge = 1'b0;
    endcase
  end

  // Vanish has priority over a move; idle slots keep their position at 0,0.
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_edge_kill = 1'b0;
    case (r_state)
      IDLE: begin
        if (claim) begin
          w_state_nxt = FLY;
          w_x_nxt     = tank_x;
          w_y_nxt     = tank_y;
        end
      end
      FLY: begin
        if (vanish) begin
          w_state_nxt = IDLE;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
        end else if (w_step) begin
          if (!w_at_edge) begin
            case (r_dir)
              UP:    w_y_nxt = r_y + POS_W'(1);
              DOWN:  w_y_nxt = r_y - POS_W'(1);
              LEFT:  w_x_nxt = r_x - POS_W'(1);
              RIGHT: w_x_nxt = r_x + POS_W'(1);
              default: ;
            endcase
          end
`ifdef SHELL_EDGE_KILL_EN
          else begin
            w_state_nxt = IDLE;
            w_edge_kill = 1'b1;
            w_x_nxt     = '0;
            w_y_nxt     = '0;
          end
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_cnt <= '0;
      r_dir <= UP;
    end else begin
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
      r_cnt <= ((r_state == FLY) && !w_step) ? r_cnt + CNT_W'(1) : '0;
      if ((r_state == IDLE) && claim) r_dir <= dir_t'(dir_in);
    end
  end

  assign pos_x     = r_x;
  assign pos_y     = r_y;
  assign active    = (r_state == FLY);
  assign edge_kill = w_edge_kill & rst_n;

endmodule

// File: rtl/shell_pool.sv
// Per-tank shell pool: lowest-free-slot allocator, fire cooldown, idle-slot count.
// Edge behaviour of the slots is selected by SHELL_EDGE_KILL_EN.
module shell_pool
  import shell_pkg::*;
#(
  parameter int N_SHELL  = 5,
  parameter int POS_W    = 6,
  parameter int STEP_DIV = 400000,
  parameter int X_MAX    = 39,
  parameter int Y_MAX    = 29,
  parameter int COOLDOWN = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        fire,
  input  logic                        give_en,
  input  logic [1:0]                  dir_in,
  input  logic [POS_W-1:0]            tank_x,
  input  logic [POS_W-1:0]            tank_y,
  input  logic [N_SHELL-1:0]          vanish,
  output logic [N_SHELL*POS_W-1:0]    shell_x,
  output logic [N_SHELL*POS_W-1:0]    shell_y,
  output logic [N_SHELL-1:0]          active,
  output logic                        fire_ack,
  output logic [idx_w(N_SHELL)-1:0]   fire_slot,
  output logic [N_SHELL-1:0]          edge_kill,
  output logic [$clog2(N_SHELL+1)-1:0] free_cnt
);

  localparam int SEL_W  = idx_w(N_SHELL);
  localparam int FREE_W = $clog2(N_SHELL + 1);
  localparam int CD_W   = idx_w(COOLDOWN + 1);

  logic              w_accept, w_any_idle;
  logic [SEL_W-1:0]  w_sel;
  logic [N_SHELL-1:0] w_claim, w_release;
  logic [FREE_W-1:0] w_rel_cnt, r_free;
  logic [CD_W-1:0]   r_cd;

  // Descending scan so the last hit is the lowest idle index.
  always_comb begin
    w_any_idle = 1'b0;
    w_sel      = '0;
    for (int unsigned i = N_SHELL; i > 0; i--) begin
      if (!active[i-1]) begin
        w_any_idle = 1'b1;
        w_sel      = SEL_W'(i - 1);
      end
    end
  end

  assign w_accept = rst_n && fire && give_en && w_any_idle && (r_cd == '0);

  always_comb begin
    w_claim = '0;
    for (int unsigned i = 0; i < N_SHELL; i++) begin
      w_claim[i] = w_accept && (w_sel == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < N_SHELL; g++) begin : g_slot
    shell_slot #(
      .POS_W   (POS_W),
      .STEP_DIV(STEP_DIV),
      .X_MAX   (X_MAX),
      .Y_MAX   (Y_MAX)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .claim    (w_claim[g]),
      .vanish   (vanish[g]),
      .dir_in   (dir_in),
      .tank_x   (tank_x),
      .tank_y   (tank_y),
      .pos_x    (shell_x[g*POS_W +: POS_W]),
      .pos_y    (shell_y[g*POS_W +: POS_W]),
      .active   (active[g]),
      .edge_kill(edge_kill[g])
    );
  end

  // Free count tracks next-state occupancy so it matches active after each edge.
  assign w_release = (vanish & active) | edge_kill;

  always_comb begin
    w_rel_cnt = '0;
    for (int unsigned i = 0; i < N_SHELL; i++) begin
      w_rel_cnt = w_rel_cnt + FREE_W'(w_release[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cd   <= '0;
      r_free <= FREE_W'(N_SHELL);
    end else begin
      if (w_accept)         r_cd <= CD_W'(COOLDOWN);
      else if (r_cd != '0)  r_cd <= r_cd - CD_W'(1);
      r_free <= r_free - FREE_W'(w_accept) + w_rel_cnt;
    end
  end

  assign fire_ack  = w_accept;
  assign fire_slot = w_sel;
  assign free_cnt  = r_free;

endmodule

// File: doc/shell_pool.md
SHELL_POOL -- requirements
Module: shell_pool

Interface
REQ-001 SHALL have parameter N_SHELL, default 5: number of shell slots per tank (1..16).
REQ-002 SHALL have parameter POS_W, default 6: coordinate width.
REQ-003 SHALL have parameter STEP_DIV, default 400000: clock cycles per one-cell shell move (>=2).
REQ-004 SHALL have parameters X_MAX and Y_MAX, default 39 and 29: the last legal arena coordinates (origin 0,0).
REQ-005 SHALL have parameter COOLDOWN, default 0: cycles after an accepted fire during which new fires are rejected (0 = none).
REQ-006 clk  in  1  sole clock; all logic on posedge clk.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 fire  in  1  fire request, level, sampled each cycle.
REQ-009 give_en  in  1  game permits firing this cycle.
REQ-010 dir_in  in  2  tank heading: 0 up (y+1), 1 down (y-1), 2 left (x-1), 3 right (x+1).
REQ-011 tank_x, tank_y  in  POS_W each  tank position, spawn point.
REQ-012 vanish  in  N_SHELL  per-slot kill from game (collision).
REQ-013 shell_x, shell_y  out  N_SHELL*POS_W each  packed slot positions, slot i at bits [i*POS_W +: POS_W].
REQ-014 active  out  N_SHELL  1 = slot in flight.
REQ-015 fire_ack  out  1  one-cycle pulse: fire accepted.
REQ-016 fire_slot  out  $clog2(N_SHELL) (min 1)  slot index taken; valid while fire_ack=1.
REQ-017 edge_kill  out  N_SHELL  one-cycle pulse per slot freed by the arena edge.
REQ-018 free_cnt  out  $clog2(N_SHELL+1)  number of idle slots, registered.

Function
REQ-019 Each slot SHALL be an IDLE/FLY state machine; active = (state == FLY).
REQ-020 Fire SHALL be accepted when fire=1, give_en=1, at least one slot is IDLE and the cooldown counter is 0.
REQ-021 An accepted fire SHALL claim the lowest-index IDLE slot only; exactly one slot per cycle.
REQ-022 On acceptance the slot SHALL latch tank_x/tank_y/dir_in, enter FLY and clear its step counter next edge; fire_ack/fire_slot SHALL be combinational in the accept cycle.
REQ-023 A FLY slot SHALL move one cell in its latched direction every STEP_DIV cycles, first move STEP_DIV cycles after the accept edge.
REQ-024 A held fire SHALL fire again each cycle the accept conditions hold (no edge detection).
REQ-025 vanish[i]=1 on a FLY slot SHALL return it to IDLE next edge; vanish SHALL win over a simultaneous move; vanish on an IDLE slot SHALL be ignored.
REQ-026 A slot vanished in cycle t SHALL NOT be claimable until cycle t+1.
REQ-027 Accepted fire SHALL load the cooldown counter with COOLDOWN; it SHALL decrement to 0 each cycle.
REQ-028 IDLE slots SHALL output position 0,0.
REQ-029 Movement arithmetic SHALL never wrap: a move beyond 0 or X_MAX/Y_MAX is the edge case of REQ-034.

Reset
REQ-030 rst_n=0 at a posedge SHALL force all slots IDLE, positions 0, step and cooldown counters 0, edge_kill 0, free_cnt N_SHELL.
REQ-031 Reset mid-flight SHALL abort all shells; fire_ack SHALL be 0 while rst_n=0.

Configuration
REQ-032 Macro SHELL_EDGE_KILL_EN selects edge behaviour.
REQ-033 Without SHELL_EDGE_KILL_EN a shell at the edge SHALL hold position, stay FLY until vanish; edge_kill tied 0.
REQ-034 With SHELL_EDGE_KILL_EN a move that would leave [0,X_MAX]x[0,Y_MAX] SHALL instead set the slot IDLE next edge and pulse edge_kill[i] that cycle.

Structure
REQ-035 Package shell_pkg SHALL hold dir_t (UP, DOWN, LEFT, RIGHT) and slot_state_t (IDLE, FLY).
REQ-036 Sub-module shell_slot SHALL implement one slot (FSM, step counter, position, edge check); shell_pool SHALL add allocator, cooldown and free counter.

Verification (bench: N_SHELL=5, STEP_DIV=4, X_MAX=39, Y_MAX=29)
REQ-037 tank (10,10), dir 3, fire 1 cycle -> fire_ack, slot 0; shell_x[0] 11 after 4 cycles, 12 after 8.
REQ-038 active=5'b00101, fire -> fire_slot=1, active=5'b00111, free_cnt 2.
REQ-039 all five active, fire held -> no ack; vanish[3] at t -> ack at t+1 with fire_slot=3.
REQ-040 EDGE_KILL_EN, tank (39,5), dir 3, fire -> after 4 cycles edge_kill[0] pulse, active[0]=0; without macro shell_x[0] stays 39, active[0]=1.
REQ-041 COOLDOWN=3, fire held 6 cycles -> acks at cycles 0 and 4 only.
REQ-042 two slots flying, rst_n=0 one cycle -> active 0, positions 0, free_cnt 5.
